// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: field widths, opcode/funct encodings and
// small decode helpers used by the ID/EX stage.
package mips_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int RA_W_DEF   = 5;
   localparam int OP_W       = 6;
   localparam int FN_W       = 6;
   localparam int IMM_W      = 16;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [FN_W-1:0] FN_ADD   = 6'h20;
   localparam logic [FN_W-1:0] FN_SUB   = 6'h22;
   localparam logic [FN_W-1:0] FN_AND   = 6'h24;
   localparam logic [FN_W-1:0] FN_OR    = 6'h25;

   function automatic logic is_load(input logic [OP_W-1:0] op);
      return (op == OP_LW);
   endfunction

endpackage

// File: rtl/id_ex_reg_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load still sitting in EX.
module hazard_detect
   import mips_pkg::*;
#(
   parameter int RA_W = 5
)(
   input  logic            id_valid,
   input  logic [RA_W-1:0] id_rs_addr,
   input  logic [RA_W-1:0] id_rt_addr,
   input  logic            ex_valid,
   input  logic [OP_W-1:0] ex_opcode,
   input  logic [RA_W-1:0] ex_rt_addr,
   output logic            hazard_stall
);

   // Compare the EX load destination against both ID source specifiers
   always_comb begin
      hazard_stall = id_valid & ex_valid & is_load(ex_opcode)
                   & (ex_rt_addr != {RA_W{1'b0}})
                   & ((ex_rt_addr == id_rs_addr) | (ex_rt_addr == id_rt_addr));
   end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush, stall hold and load-use bubble.
// Optional write-back bypass into the operand latches: define ID_WB_BYPASS_EN.
module id_ex_reg
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [OP_W-1:0]   id_opcode,
   input  logic [FN_W-1:0]   id_funct,
   input  logic [RA_W-1:0]   id_rs_addr,
   input  logic [RA_W-1:0]   id_rt_addr,
   input  logic [RA_W-1:0]   id_rd_addr,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [IMM_W-1:0]  id_imm,
   input  logic              wb_write,
   input  logic [RA_W-1:0]   wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc,
   output logic [OP_W-1:0]   ex_opcode,
   output logic [FN_W-1:0]   ex_funct,
   output logic [RA_W-1:0]   ex_rs_addr,
   output logic [RA_W-1:0]   ex_rt_addr,
   output logic [RA_W-1:0]   ex_rd_addr,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm32,
   output logic              hazard_stall
);

   logic              ex_valid_r;
   logic [DATA_W-1:0] ex_pc_r;
   logic [OP_W-1:0]   ex_opcode_r;
   logic [FN_W-1:0]   ex_funct_r;
   logic [RA_W-1:0]   ex_rs_addr_r;
   logic [RA_W-1:0]   ex_rt_addr_r;
   logic [RA_W-1:0]   ex_rd_addr_r;
   logic [DATA_W-1:0] ex_rs_data_r;
   logic [DATA_W-1:0] ex_rt_data_r;
   logic [DATA_W-1:0] ex_imm32_r;

   logic [DATA_W-1:0] rs_src_s;
   logic [DATA_W-1:0] rt_src_s;
   logic [DATA_W-1:0] rs_next_s;
   logic [DATA_W-1:0] rt_next_s;
   logic [DATA_W-1:0] imm_ext_s;

`ifdef ID_WB_BYPASS_EN
   // Same-cycle write-back overrides the stale register-file read
   always_comb begin
      if (wb_write && (wb_addr != {RA_W{1'b0}}) && (wb_addr == id_rs_addr)) begin
         rs_src_s = wb_data;
      end else begin
         rs_src_s = id_rs_data;
      end
      if (wb_write && (wb_addr != {RA_W{1'b0}}) && (wb_addr == id_rt_addr)) begin
         rt_src_s = wb_data;
      end else begin
         rt_src_s = id_rt_data;
      end
   end
`else
   logic unused_wb_s;
   assign unused_wb_s = ^{wb_write, wb_addr, wb_data};

   // Register file already resolves write-before-read
   always_comb begin
      rs_src_s = id_rs_data;
      rt_src_s = id_rt_data;
   end
`endif

   // $0 always reads as zero; immediate is sign-extended to the datapath
   always_comb begin
      rs_next_s = (id_rs_addr == {RA_W{1'b0}}) ? {DATA_W{1'b0}} : rs_src_s;
      rt_next_s = (id_rt_addr == {RA_W{1'b0}}) ? {DATA_W{1'b0}} : rt_src_s;
      imm_ext_s = {{(DATA_W-IMM_W){id_imm[IMM_W-1]}}, id_imm};
   end

   hazard_detect #(.RA_W(RA_W)) u_hazard (
      .id_valid     (id_valid),
      .id_rs_addr   (id_rs_addr),
      .id_rt_addr   (id_rt_addr),
      .ex_valid     (ex_valid_r),
      .ex_opcode    (ex_opcode_r),
      .ex_rt_addr   (ex_rt_addr_r),
      .hazard_stall (hazard_stall)
   );

   // Stage update, priority rst > flush > stall > bubble > load
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_r   <= 1'b0;
         ex_pc_r      <= {DATA_W{1'b0}};
         ex_opcode_r  <= {OP_W{1'b0}};
         ex_funct_r   <= {FN_W{1'b0}};
         ex_rs_addr_r <= {RA_W{1'b0}};
         ex_rt_addr_r <= {RA_W{1'b0}};
         ex_rd_addr_r <= {RA_W{1'b0}};
         ex_rs_data_r <= {DATA_W{1'b0}};
         ex_rt_data_r <= {DATA_W{1'b0}};
         ex_imm32_r   <= {DATA_W{1'b0}};
      end else if (flush || (!stall && hazard_stall)) begin
         ex_valid_r  <= 1'b0;
         ex_opcode_r <= {OP_W{1'b0}};
         ex_funct_r  <= {FN_W{1'b0}};
      end else if (!stall) begin
         ex_valid_r   <= id_valid;
         ex_pc_r      <= id_pc;
         ex_opcode_r  <= id_opcode;
         ex_funct_r   <= id_funct;
         ex_rs_addr_r <= id_rs_addr;
         ex_rt_addr_r <= id_rt_addr;
         ex_rd_addr_r <= id_rd_addr;
         ex_rs_data_r <= rs_next_s;
         ex_rt_data_r <= rt_next_s;
         ex_imm32_r   <= imm_ext_s;
      end
   end

   assign ex_valid   = ex_valid_r;
   assign ex_pc      = ex_pc_r;
   assign ex_opcode  = ex_opcode_r;
   assign ex_funct   = ex_funct_r;
   assign ex_rs_addr = ex_rs_addr_r;
   assign ex_rt_addr = ex_rt_addr_r;
   assign ex_rd_addr = ex_rd_addr_r;
   assign ex_rs_data = ex_rs_data_r;
   assign ex_rt_data = ex_rt_data_r;
   assign ex_imm32   = ex_imm32_r;

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DATA_W, 32, datapath width.
REQ-002 Parameter RA_W, 5, register address width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall  in  1  downstream (EX) hold request.
REQ-006 flush  in  1  discard the ID instruction (branch/jump redirect).
REQ-007 id_valid  in  1  ID slot holds a real instruction.
REQ-008 id_pc  in  DATA_W  instruction PC.
REQ-009 id_opcode, id_funct  in  6 each  instruction opcode and funct fields.
REQ-010 id_rs_addr, id_rt_addr, id_rd_addr  in  RA_W each  register specifiers.
REQ-011 id_rs_data, id_rt_data  in  DATA_W each  register-file read ports (combinational reads).
REQ-012 id_imm  in  16  raw immediate.
REQ-013 wb_write, wb_addr, wb_data  in  1/RA_W/DATA_W  write-back port driving the register file this cycle.
REQ-014 ex_valid  out  1; ex_pc, ex_rs_data, ex_rt_data, ex_imm32  out  DATA_W; ex_opcode, ex_funct  out  6; ex_rs_addr, ex_rt_addr, ex_rd_addr  out  RA_W: registered EX-stage fields.
REQ-015 hazard_stall  out  1  combinational; freeze PC and IF/ID.

Function
REQ-016 Update priority each posedge: rst > flush > stall hold > load-use bubble > normal load.
REQ-017 Normal load: all ex_* take the corresponding id_* values one cycle later; ex_valid <= id_valid.
REQ-018 ex_imm32 = sign-extend(id_imm) to DATA_W (bit 15 replicated).
REQ-019 Register $0: ex_rs_data/ex_rt_data latch 0 when the matching address is 0, regardless of id_*_data or bypass.
REQ-020 flush=1 (stall any value): ex_valid <= 0, ex_opcode/ex_funct <= 0, all other ex_* keep values.
REQ-021 stall=1 and flush=0: every ex_* register holds.
REQ-022 hazard_stall = id_valid & ex_valid & (ex_opcode == OP_LW) & (ex_rt_addr != 0) & (ex_rt_addr == id_rs_addr | ex_rt_addr == id_rt_addr).
REQ-023 hazard_stall=1, stall=0, flush=0: bubble inserted (ex_valid <= 0, ex_opcode/ex_funct <= 0); next cycle the held ID instruction reloads normally.
REQ-024 hazard_stall evaluated from current registered ex_* state; it deasserts automatically after one bubble.
REQ-025 Bubble and flush never assert hazard_stall in the following cycle (ex_valid=0).
REQ-026 Invalid instruction (id_valid=0) latched with ex_valid=0; data fields still load.

Reset
REQ-027 rst=1 at posedge: all ex_* outputs <= 0 (ex_valid=0); hazard_stall therefore 0 the following cycle.
REQ-028 rst mid-stall or mid-bubble discards held instruction; no state survives.

Configuration
REQ-029 Macro ID_WB_BYPASS_EN defined: if wb_write & wb_addr != 0 & wb_addr == id_rs_addr, latch wb_data into ex_rs_data instead of id_rs_data; same for rt.
REQ-030 Macro undefined: id_rs_data/id_rt_data latched unmodified; wb_* inputs unused (write-before-read resolved elsewhere).

Structure
REQ-031 Shared package mips_pkg holds OP_LW (6'h23), opcode/funct constants and width localparams.
REQ-032 One sub-module hazard_detect computes hazard_stall (REQ-022) purely combinationally.

Verification
REQ-033 rst=1 one cycle with all id_* = nonzero -> next cycle every ex_* = 0, hazard_stall=0.
REQ-034 id_valid=1, id_imm=16'h8001, id_rs_addr=3, id_rs_data=32'h12 -> next cycle ex_imm32=32'hFFFF8001, ex_rs_data=32'h12, ex_valid=1.
REQ-035 EX holds LW with rt=5, ID presents rs=5 -> hazard_stall=1; next cycle ex_valid=0, hazard_stall=0; following cycle instruction with rs=5 loaded, ex_valid=1.
REQ-036 stall=1 for 3 cycles with changing id_* -> ex_* unchanged; flush=1 with stall=1 -> ex_valid=0 next cycle.
REQ-037 ID_WB_BYPASS_EN defined: wb_write=1, wb_addr=7, wb_data=32'hDEAD, id_rt_addr=7, id_rt_data=32'h1 -> ex_rt_data=32'hDEAD; macro undefined -> 32'h1; wb_addr=0 with id_rt_addr=0 -> 0 in both builds.
